// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler_pkg
// Description : Shared types and constants for the UART transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] frame_length;
        logic [1:0] parity_signal;
        logic       stop_bits;
    } cfg_t;

    localparam int         c_CFG_W         = 7;
    localparam logic [3:0] c_FRAME_LEN_MIN = 4'd5;
    localparam logic [3:0] c_FRAME_LEN_MAX = 4'd8;

    function automatic logic frame_len_ok(input logic [3:0] fl);
        return (fl >= c_FRAME_LEN_MIN) && (fl <= c_FRAME_LEN_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_arbiter
// Description : Combinational round-robin pick, scanning upward from i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    always_comb begin
        int j;
        j       = 0;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_valid && i_req[j]) begin
                o_valid  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Round-robin scheduler sharing one UART transmitter among
//               NUM_REQ requesters, with watchdog and inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*c_CFG_W-1:0]    req_cfg,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            err,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [3:0]                    frame_length,
    output logic [1:0]                    parity_signal,
    output logic                          stop_bits,
    output logic                          TX_detect,
    input  logic                          TX_done,
    input  logic                          TX_ERROR,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    active_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES);

    state_t                  r_state_q,   w_state_d;
    logic [IDX_W-1:0]        r_ptr_q,     w_ptr_d;
    logic [NUM_REQ-1:0]      r_gnt_q,     w_gnt_d;
    logic [NUM_REQ-1:0]      r_ack_q,     w_ack_d;
    logic [NUM_REQ-1:0]      r_err_q,     w_err_d;
    logic [DATA_WIDTH-1:0]   r_data_q,    w_data_d;
    cfg_t                    r_cfg_q,     w_cfg_d;
    logic                    r_txd_q,     w_txd_d;
    logic [IDX_W-1:0]        r_id_q,      w_id_d;
    logic [WD_W-1:0]         r_wd_q,      w_wd_d;
    logic [GAP_W-1:0]        r_gap_q,     w_gap_d;
    logic                    r_busy_q;
    logic                    r_tx_done_q;

    logic [NUM_REQ-1:0]      w_win_gnt;
    logic [IDX_W-1:0]        w_win_idx;
    logic                    w_win_valid;
    cfg_t                    w_win_cfg;
    logic [DATA_WIDTH-1:0]   w_win_data;
    logic                    w_done_rise;
    logic                    w_timeout;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr_q),
        .o_gnt   (w_win_gnt),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    assign w_win_cfg   = cfg_t'(req_cfg[int'(w_win_idx)*c_CFG_W +: c_CFG_W]);
    assign w_win_data  = req_data[int'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_done_rise = TX_done & ~r_tx_done_q;
    assign w_timeout   = (r_wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_gnt_d   = r_gnt_q;
        w_ack_d   = '0;
        w_err_d   = '0;
        w_data_d  = r_data_q;
        w_cfg_d   = r_cfg_q;
        w_txd_d   = r_txd_q;
        w_id_d    = r_id_q;
        w_wd_d    = r_wd_q;
        w_gap_d   = r_gap_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_ptr_d = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + IDX_W'(1);
                    if (frame_len_ok(w_win_cfg.frame_length)) begin
                        w_state_d = ST_BUSY;
                        w_gnt_d   = w_win_gnt;
                        w_txd_d   = 1'b1;
                        w_data_d  = w_win_data;
                        w_cfg_d   = w_win_cfg;
                        w_id_d    = w_win_idx;
                        w_wd_d    = '0;
                    end else begin
                        w_err_d = w_win_gnt;
                    end
                end
            end
            ST_BUSY: begin
                // Transmitter error and watchdog both outrank a completion edge.
                if (TX_ERROR || w_timeout || w_done_rise) begin
                    w_state_d = ST_RELEASE;
                    w_gnt_d   = '0;
                    w_txd_d   = 1'b0;
                    w_gap_d   = '0;
                    if (TX_ERROR || w_timeout) w_err_d = r_gnt_q;
                    else                       w_ack_d = r_gnt_q;
                end else begin
                    w_wd_d = r_wd_q + WD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (r_gap_q == GAP_W'(GAP_CYCLES - 1)) w_state_d = ST_IDLE;
                else                                   w_gap_d   = r_gap_q + GAP_W'(1);
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state_q   <= ST_IDLE;
            r_ptr_q     <= '0;
            r_gnt_q     <= '0;
            r_ack_q     <= '0;
            r_err_q     <= '0;
            r_data_q    <= '0;
            r_cfg_q     <= '0;
            r_txd_q     <= 1'b0;
            r_id_q      <= '0;
            r_wd_q      <= '0;
            r_gap_q     <= '0;
            r_busy_q    <= 1'b0;
            r_tx_done_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_ptr_q     <= w_ptr_d;
            r_gnt_q     <= w_gnt_d;
            r_ack_q     <= w_ack_d;
            r_err_q     <= w_err_d;
            r_data_q    <= w_data_d;
            r_cfg_q     <= w_cfg_d;
            r_txd_q     <= w_txd_d;
            r_id_q      <= w_id_d;
            r_wd_q      <= w_wd_d;
            r_gap_q     <= w_gap_d;
            r_busy_q    <= (w_state_d != ST_IDLE);
            r_tx_done_q <= TX_done;
        end
    end

    assign gnt           = r_gnt_q;
    assign ack           = r_ack_q;
    assign err           = r_err_q;
    assign write_data    = r_data_q;
    assign frame_length  = r_cfg_q.frame_length;
    assign parity_signal = r_cfg_q.parity_signal;
    assign stop_bits     = r_cfg_q.stop_bits;
    assign TX_detect     = r_txd_q;
    assign busy          = r_busy_q;
    assign active_id     = r_id_q;

endmodule
`default_nettype wire
